timer_mc_wb: RTL and testbench

TIMER_MC_WB -- requirements
Module: timer_mc_wb

---
 rtl/timer_mc_wb.sv | 143 ++++++++++++++
 tb/tb_timer_mc_wb.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_mc_wb.sv
// Wishbone timer: prescaled 64-bit mtime with NCMP compare channels and a level interrupt.
// Define TIMER_MC_SNAPSHOT_EN to latch mtime[63:32] on MTIME_L reads, making 64-bit reads coherent.
module timer_mc_wb #(
  parameter int NCMP       = 2,
  parameter int PRESCALE_W = 16
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic [5:2]  wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  input  logic        wb_we_i,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_stb_i,
  output logic        wb_ack_o,
  output logic        int_o
);

  localparam logic [3:0] A_MTL  = 4'd0;
  localparam logic [3:0] A_MTH  = 4'd1;
  localparam logic [3:0] A_CTRL = 4'd2;
  localparam logic [3:0] A_PRE  = 4'd3;
  localparam logic [3:0] A_IE   = 4'd4;
  localparam logic [3:0] A_IP   = 4'd5;

  logic [63:0]            mtime_q, mtime_d;
  logic [NCMP-1:0][63:0]  cmp_q, cmp_d;
  logic                   en_q, en_d;
  logic [PRESCALE_W-1:0]  presc_q, presc_d, cnt_q, cnt_d;
  logic [NCMP-1:0]        ie_q, ie_d, ip;
  logic                   ack_q;
  logic [31:0]            dat_q, dat_d, rdat, tmp;
  logic                   wr, rd, tick;

  function automatic logic [31:0] bmerge(input logic [31:0] old, input logic [31:0] nw,
                                         input logic [3:0] sel);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[8*b +: 8] = sel[b] ? nw[8*b +: 8] : old[8*b +: 8];
    return r;
  endfunction

  always_comb begin
    wr   = wb_stb_i & wb_we_i & ~ack_q;
    rd   = wb_stb_i & ~wb_we_i & ~ack_q;
    tick = en_q && (cnt_q == '0);

    mtime_d = tick ? mtime_q + 64'd1 : mtime_q;
    cmp_d   = cmp_q;
    en_d    = en_q;
    presc_d = presc_q;
    ie_d    = ie_q;
    tmp     = '0;

    // An mtime write takes precedence over, and discards, the same-cycle tick.
    if (wr) begin
      case (wb_adr_i)
        A_MTL:  mtime_d = {mtime_q[63:32], bmerge(mtime_q[31:0], wb_dat_i, wb_sel_i)};
        A_MTH:  mtime_d = {bmerge(mtime_q[63:32], wb_dat_i, wb_sel_i), mtime_q[31:0]};
        A_CTRL: en_d = wb_sel_i[0] ? wb_dat_i[0] : en_q;
        A_PRE: begin
          tmp     = bmerge(32'(presc_q), wb_dat_i, wb_sel_i);
          presc_d = tmp[PRESCALE_W-1:0];
        end
        A_IE: begin
          tmp  = bmerge(32'(ie_q), wb_dat_i, wb_sel_i);
          ie_d = tmp[NCMP-1:0];
        end
        default: ;
      endcase
      for (int k = 0; k < NCMP; k++) begin
        if (wb_adr_i == 4'(8 + 2*k))
          cmp_d[k][31:0]  = bmerge(cmp_q[k][31:0], wb_dat_i, wb_sel_i);
        if (wb_adr_i == 4'(9 + 2*k))
          cmp_d[k][63:32] = bmerge(cmp_q[k][63:32], wb_dat_i, wb_sel_i);
      end
    end

    cnt_d = cnt_q;
    if (en_q) cnt_d = tick ? presc_q : cnt_q - PRESCALE_W'(1);
    if (wr && wb_adr_i == A_PRE) cnt_d = presc_d;
  end

  always_comb begin
    for (int k = 0; k < NCMP; k++) ip[k] = (mtime_q >= cmp_q[k]);
  end

`ifdef TIMER_MC_SNAPSHOT_EN
  logic [31:0] shadow_q;
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i)                      shadow_q <= '0;
    else if (rd && wb_adr_i == A_MTL)  shadow_q <= mtime_q[63:32];
  end
`endif

  always_comb begin
    rdat = '0;
    case (wb_adr_i)
      A_MTL:  rdat = mtime_q[31:0];
`ifdef TIMER_MC_SNAPSHOT_EN
      A_MTH:  rdat = shadow_q;
`else
      A_MTH:  rdat = mtime_q[63:32];
`endif
      A_CTRL: rdat = {31'd0, en_q};
      A_PRE:  rdat = 32'(presc_q);
      A_IE:   rdat = 32'(ie_q);
      A_IP:   rdat = 32'(ip);
      default: ;
    endcase
    for (int k = 0; k < NCMP; k++) begin
      if (wb_adr_i == 4'(8 + 2*k)) rdat = cmp_q[k][31:0];
      if (wb_adr_i == 4'(9 + 2*k)) rdat = cmp_q[k][63:32];
    end
    dat_d = rd ? rdat : '0;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      mtime_q <= '0;
      cmp_q   <= '1;
      en_q    <= 1'b1;
      presc_q <= '0;
      cnt_q   <= '0;
      ie_q    <= '0;
      ack_q   <= 1'b0;
      dat_q   <= '0;
    end else begin
      mtime_q <= mtime_d;
      cmp_q   <= cmp_d;
      en_q    <= en_d;
      presc_q <= presc_d;
      cnt_q   <= cnt_d;
      ie_q    <= ie_d;
      ack_q   <= wb_stb_i & ~ack_q;
      dat_q   <= dat_d;
    end
  end

  assign wb_ack_o = ack_q;
  assign wb_dat_o = dat_q;
  assign int_o    = |(ip & ie_q);

endmodule

// File: tb/tb_timer_mc_wb.sv
// Randomized self-checking bench for timer_mc_wb; mtime expectations come from cycle arithmetic.
module tb_timer_mc_wb;
  localparam int NCMP = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  adr = '0;
  logic [31:0] dat = '0;
  logic [31:0] dat_o;
  logic        we = 1'b0;
  logic [3:0]  sel = '0;
  logic        stb = 1'b0;
  logic        ack;
  logic        int_o;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  logic [63:0]     cmp_m [4];
  logic [NCMP-1:0] ie_m;

  timer_mc_wb #(.NCMP(NCMP), .PRESCALE_W(16)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .wb_adr_i(adr), .wb_dat_i(dat), .wb_dat_o(dat_o),
    .wb_we_i(we), .wb_sel_i(sel), .wb_stb_i(stb), .wb_ack_o(ack), .int_o(int_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                        input logic [3:0] s);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[8*b +: 8] = s[b] ? n[8*b +: 8] : o[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] mexp(input logic [3:0] a);
    int k;
    logic [31:0] r;
    r = '0;
    if (a == 4) r = 32'(ie_m);
    else if (a >= 8) begin
      k = (int'(a) - 8) / 2;
      if (k < NCMP) r = a[0] ? cmp_m[k][63:32] : cmp_m[k][31:0];
    end
    return r;
  endfunction

  // One access: stb for one edge, then one idle edge so the next access is a fresh one.
  task automatic bus(input logic [3:0] a, input logic w, input logic [31:0] d,
                     input logic [3:0] s, output logic [31:0] rdv, output int e);
    @(negedge clk);
    adr = a; we = w; dat = d; sel = s; stb = 1'b1;
    @(posedge clk); #1;
    e = cyc;
    chk("ack", ack, 1'b1);
    rdv = dat_o;
    stb = 1'b0; we = 1'b0;
    @(posedge clk); #1;
    chk("ack_pulse", ack, 1'b0);
  endtask

  task automatic mw(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                    output int e);
    logic [31:0] t;
    int k;
    if (a == 4) begin
      t = merge(32'(ie_m), d, s);
      ie_m = t[NCMP-1:0];
    end else if (a >= 8) begin
      k = (int'(a) - 8) / 2;
      if (k < NCMP) begin
        if (a[0]) cmp_m[k][63:32] = merge(cmp_m[k][63:32], d, s);
        else      cmp_m[k][31:0]  = merge(cmp_m[k][31:0], d, s);
      end
    end
    bus(a, 1'b1, d, s, t, e);
  endtask

  task automatic rd(input logic [3:0] a, output logic [31:0] v, output int e);
    bus(a, 1'b0, 32'd0, 4'hF, v, e);
  endtask

  task automatic mreset();
    for (int k = 0; k < 4; k++) cmp_m[k] = '1;
    ie_m = '0;
  endtask

  initial begin
    logic [31:0] v, d;
    logic [63:0] mv, ipx;
    int e, e0, ew, ed, el, er, er2, p, base, gap, a, a2, frz;
    logic [3:0] s;

    mreset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack", ack, 1'b0);
    chk("rst_dat", dat_o, 32'd0);
    chk("rst_int", int_o, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    e0 = cyc;

    // Reset state; mtime free-runs one per cycle with PRESCALE=0.
    rd(4'd0, v, er);  chk("rst_mtl", v, 32'(er - 1 - e0));
    rd(4'd1, v, er);  chk("rst_mth", v, 0);
    rd(4'd2, v, er);  chk("rst_ctrl", v, 1);
    rd(4'd3, v, er);  chk("rst_pre", v, 0);
    rd(4'd4, v, er);  chk("rst_ie", v, 0);
    rd(4'd5, v, er);  chk("rst_ip", v, 0);
    rd(4'd8, v, er);  chk("rst_cmpl0", v, 32'hFFFF_FFFF);
    rd(4'd11, v, er); chk("rst_cmph1", v, 32'hFFFF_FFFF);

    // Byte enables.
    d = $urandom | 32'h00FF_0000;
    d[23:16] = 8'hA5;
    mw(4'd8, d, 4'b0100, e);
    rd(4'd8, v, er); chk("bytesel", v, 32'hFFA5_FFFF);

    // Random register traffic against the model, including IP/unmapped/out-of-range writes.
    for (int i = 0; i < 24; i++) begin
      a = $urandom_range(4, 15);
      d = $urandom;
      s = 4'($urandom_range(0, 15));
      mw(4'(a), d, s, e);
      a2 = $urandom_range(4, 15);
      if (a2 == 5) a2 = a;
      if (a2 == 5) a2 = 4;
      rd(4'(a2), v, er);
      chk("rand_reg", v, mexp(4'(a2)));
    end

    // Prescaler: mtime = floor(k/(P+1)) k cycles after enabling with counter loaded to P.
    for (int r = 0; r < 2; r++) begin
      p = (r == 0) ? 3 : $urandom_range(0, 6);
      mw(4'd2, 32'd0, 4'hF, e);
      mw(4'd3, 32'(p), 4'hF, e);
      mw(4'd0, 32'd0, 4'hF, e);
      mw(4'd1, 32'd0, 4'hF, e);
      mw(4'd2, 32'd1, 4'hF, ew);
      for (int i = 0; i < 6; i++) begin
        gap = $urandom_range(0, 5);
        repeat (gap) @(posedge clk);
        rd(4'd0, v, er);
        chk("presc_run", v, 32'((er - 1 - ew) / (p + 1)));
      end
      mw(4'd2, 32'd0, 4'hF, ed);
      frz = (ed - ew) / (p + 1);
      repeat (20) @(posedge clk);
      rd(4'd0, v, er); chk("frozen_a", v, 32'(frz));
      repeat ($urandom_range(1, 5)) @(posedge clk);
      rd(4'd0, v, er); chk("frozen_b", v, 32'(frz));
      rd(4'd1, v, er); chk("frozen_h", v, 0);
    end

    // Wrap-around.
    mw(4'd3, 32'd0, 4'hF, e);
    mw(4'd2, 32'd1, 4'hF, e);
    mw(4'd1, 32'hFFFF_FFFF, 4'hF, e);
    mw(4'd0, 32'hFFFF_FFFE, 4'hF, el);
    rd(4'd0, v, er);
    mv = 64'hFFFF_FFFF_FFFF_FFFE + 64'(er - 1 - el);
    chk("wrap_l", v, mv[31:0]);
    rd(4'd1, v, er2);
`ifdef TIMER_MC_SNAPSHOT_EN
    chk("wrap_h", v, mv[63:32]);
`else
    mv = 64'hFFFF_FFFF_FFFF_FFFE + 64'(er2 - 1 - el);
    chk("wrap_h", v, mv[63:32]);
`endif
    rd(4'd0, v, er);
    mv = 64'hFFFF_FFFF_FFFF_FFFE + 64'(er - 1 - el);
    chk("wrap_l2", v, mv[31:0]);

    // Compare channel 1 drives int_o when mtime reaches 100.
    base = 100 - $urandom_range(30, 60);
    mw(4'd1, 32'd0, 4'hF, e);
    mw(4'd0, 32'(base), 4'hF, el);
    mw(4'd11, 32'd0, 4'hF, e);
    mw(4'd10, 32'd100, 4'hF, e);
    mw(4'd4, 32'd2, 4'hF, e);
    for (int i = 0; i < 80; i++) begin
      @(posedge clk); #1;
      chk("int_rise", int_o, (base + cyc - el) >= 100);
    end
    rd(4'd5, v, er);
    mv = 64'(base + er - 1 - el);
    ipx = '0;
    for (int k = 0; k < NCMP; k++) ipx[k] = (mv >= cmp_m[k]);
    chk("ip_read", v, ipx);
    mw(4'd10, 32'hFFFF_FFFF, 4'hF, e);
    chk("int_fall_l", int_o, 1'b0);
    mw(4'd11, 32'hFFFF_FFFF, 4'hF, e);
    chk("int_fall_h", int_o, 1'b0);

    // Snapshot coherence across a low-word carry.
    mw(4'd1, 32'd0, 4'hF, e);
    mw(4'd0, 32'hFFFF_FFF0, 4'hF, el);
    rd(4'd0, v, er);
    mv = 64'h0000_0000_FFFF_FFF0 + 64'(er - 1 - el);
    chk("snap_l", v, mv[31:0]);
    repeat (40) @(posedge clk);
    rd(4'd1, v, er2);
`ifdef TIMER_MC_SNAPSHOT_EN
    chk("snap_h", v, mv[63:32]);
`else
    mv = 64'h0000_0000_FFFF_FFF0 + 64'(er2 - 1 - el);
    chk("snap_h", v, mv[63:32]);
`endif

    // Reset in the stb cycle of a CMP_L[0] write aborts it.
    mw(4'd4, 32'd1, 4'hF, e);
    @(negedge clk);
    adr = 4'd8; we = 1'b1; dat = 32'd0; sel = 4'hF; stb = 1'b1; rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid_ack", ack, 1'b0);
    chk("rst_mid_int", int_o, 1'b0);
    stb = 1'b0; we = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    mreset();
    rd(4'd8, v, er); chk("rst_mid_cmp", v, 32'hFFFF_FFFF);
    rd(4'd4, v, er); chk("rst_mid_ie", v, 0);
    rd(4'd1, v, er); chk("rst_mid_mth", v, 0);
    chk("rst_mid_int2", int_o, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
